// File: rtl/ex_mem_stage.sv
// ex_mem_stage: LEGv8 execute stage with EX/MEM register and NZVC flag register.
// Define FLAG_BYPASS_EN to add byp_* outputs that forward freshly computed flags.
module ex_mem_stage #(
    parameter int WIDTH = 64,
    parameter int RD_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] Da,
    input  logic [WIDTH-1:0] Db,
    input  logic [11:0]      Imm12,
    input  logic [8:0]       D9,
    input  logic [5:0]       Shamt,
    input  logic [RD_W-1:0]  Rd,
    input  logic [2:0]       ctrl,
    input  logic             mem_wr,
    input  logic             reg_wr,
    input  logic             alu_src,
    input  logic             mem_to_reg,
    input  logic             setFlags,
    input  logic             shift,
    input  logic             imm_or_D9,
    output logic [WIDTH-1:0] EX_result,
    output logic [WIDTH-1:0] EX_Db,
    output logic [RD_W-1:0]  EX_Rd,
    output logic             EX_mem_wr,
    output logic             EX_reg_wr,
    output logic             EX_mem_to_reg,
    output logic             EX_valid,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
`ifdef FLAG_BYPASS_EN
    ,
    output logic             byp_n,
    output logic             byp_z,
    output logic             byp_v,
    output logic             byp_c
`endif
);
    logic [WIDTH-1:0] b, bx, res;
    logic [WIDTH:0]   sum;
    logic             sub, arith, n, z, v, c;
    always_comb begin
        b = !alu_src ? Db : imm_or_D9 ? {{(WIDTH-9){D9[8]}}, D9} : {{(WIDTH-12){1'b0}}, Imm12};
        sub = ctrl == 3'b011;
        bx = sub ? ~b : b;
        sum = {1'b0, Da} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        arith = !shift && ctrl[2:1] == 2'b01;
        res = shift ? Da >> Shamt :
              ctrl == 3'b000 ? b :
              arith ? sum[WIDTH-1:0] :
              ctrl == 3'b100 ? Da & b :
              ctrl == 3'b101 ? Da | b :
              ctrl == 3'b110 ? Da ^ b : '0;
        n = res[WIDTH-1];
        z = res == '0;
        c = arith & sum[WIDTH];
        v = arith & (Da[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != Da[WIDTH-1]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_result <= '0;
            EX_Db <= '0;
            EX_Rd <= '0;
            EX_mem_wr <= 1'b0;
            EX_reg_wr <= 1'b0;
            EX_mem_to_reg <= 1'b0;
            EX_valid <= 1'b0;
            {flag_n, flag_z, flag_v, flag_c} <= 4'b0;
        end else if (flush) begin
            EX_result <= '0;
            EX_Db <= '0;
            EX_Rd <= '0;
            EX_mem_wr <= 1'b0;
            EX_reg_wr <= 1'b0;
            EX_mem_to_reg <= 1'b0;
            EX_valid <= 1'b0;
        end else if (!stall) begin
            EX_result <= res;
            EX_Db <= Db;
            EX_Rd <= Rd;
            EX_mem_wr <= mem_wr & in_valid;
            EX_reg_wr <= reg_wr & in_valid;
            EX_mem_to_reg <= mem_to_reg;
            EX_valid <= in_valid;
            if (setFlags && in_valid) {flag_n, flag_z, flag_v, flag_c} <= {n, z, v, c};
        end
    end
`ifdef FLAG_BYPASS_EN
    // Forwarding ignores stall so ID sees the flags of the instruction sitting in EX.
    assign {byp_n, byp_z, byp_v, byp_c} = (setFlags && in_valid && !flush) ?
                                          {n, z, v, c} : {flag_n, flag_z, flag_v, flag_c};
`endif
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage LEGv8 pipeline.
- Consumes the registered ID/EX bundle: operands, immediates, shamt, Rd, ALU ctrl and control flags.
- Computes operand-B select, ALU or shift result and NZVC flags.
- Holds the flags in an architectural flag register and registers result, store data, Rd and memory/writeback controls for the MEM stage.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
WIDTH, 64, datapath width; Da, Db and result width.
RD_W, 5, destination register index width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
stall  input  1  hold all stage state this cycle.
flush  input  1  load a bubble into EX/MEM this cycle.
in_valid  input  1  ID/EX slot holds a real instruction.
Da  input  WIDTH  operand A (Rn value).
Db  input  WIDTH  operand B (Rm value; also store data).
Imm12  input  12  unsigned immediate.
D9  input  9  signed address offset.
Shamt  input  6  shift amount.
Rd  input  RD_W  destination register.
ctrl  input  3  ALU op.
mem_wr, reg_wr, alu_src, mem_to_reg, setFlags, shift, imm_or_D9  input  1 each  control flags from ID/EX.
EX_result  output  WIDTH  registered ALU/shift result (address for load/store).
EX_Db  output  WIDTH  registered store data.
EX_Rd  output  RD_W  registered destination.
EX_mem_wr, EX_reg_wr, EX_mem_to_reg, EX_valid  output  1 each  registered controls.
flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flag register.

Behaviour:
- Reset (rst=1 at posedge): every output is 0. Reset overrides stall and flush.
- Operand B:
  - alu_src=0: Db.
  - alu_src=1, imm_or_D9=1: D9 sign-extended to WIDTH.
  - alu_src=1, imm_or_D9=0: Imm12 zero-extended.
- ALU ctrl encodings:
  - 000: pass B.
  - 010: A+B.
  - 011: A-B, computed as A+~B+1.
  - 100: A&B.
  - 101: A|B.
  - 110: A^B.
  - 001 and 111: result 0.
- shift=1 overrides ctrl: result = Da >> Shamt (logical; shamt 0..63).
- Flags from the combinational result:
  - N = result[WIDTH-1]; Z = (result == 0).
  - Add/sub: C = carry out of bit WIDTH-1 (sub C=1 means no borrow); V = signed overflow.
  - All other ops, shift and undefined codes: C=0, V=0.
- Latency: 1 cycle from ID/EX inputs to EX_* outputs.
- Normal cycle (no stall, no flush): EX_* <= computed values; EX_valid <= in_valid.
- in_valid=0: EX_mem_wr and EX_reg_wr are forced to 0; EX_valid=0.
- Flag register loads only when setFlags & in_valid & !stall & !flush; otherwise it holds.
- stall=1, flush=0: all EX_* registers and flags hold their values.
- flush=1: EX_valid, EX_mem_wr, EX_reg_wr and EX_mem_to_reg <= 0; EX_result, EX_Db and EX_Rd <= 0; flags hold. Flush wins over stall.
- Back-to-back flag setters update the flags every cycle; the last one wins.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- When defined, adds four outputs byp_n, byp_z, byp_v, byp_c.
  - They equal the freshly computed flags in the same cycle when setFlags & in_valid & !flush.
  - Otherwise they equal the flag register.
  - This lets B.cond in the ID stage see flags from the instruction currently in EX without a bubble.
- When undefined, the ports are absent and branch logic uses flag_* only (one-cycle flag latency).

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all EX_* and flag_* outputs are 0; deassert -> first valid ADD appears one cycle later.
- ADDS: Da=0x7FFF_FFFF_FFFF_FFFF, Db=1, ctrl=010, setFlags=1 -> EX_result=0x8000_0000_0000_0000; N=1, Z=0, V=1, C=0.
- SUBS: Da=5, Db=5, ctrl=011 -> result 0; Z=1, C=1, V=0.
- SUBS: Da=0, Db=1, ctrl=011 -> result 0xFFFF_FFFF_FFFF_FFFF; N=1, C=0.
- LDUR address: alu_src=1, imm_or_D9=1, D9=0x1F8 (-8), Da=0x100, ctrl=010, mem_to_reg=1 -> EX_result=0xF8, EX_mem_to_reg=1; flags unchanged (setFlags=0).
- LSR: shift=1, Da=0xF0, Shamt=4 -> EX_result=0xF; ctrl ignored.
- Stall/flush: a valid ADD with stall=1 -> EX_* unchanged; next cycle stall=1 and flush=1 together -> EX_valid=0, EX_reg_wr=0, flags unchanged.
- FLAG_BYPASS_EN: SUBS 3-3 in EX -> byp_z=1 the same cycle while flag_z is still 0, and flag_z=1 on the next cycle.
